pcie_vc_router: RTL

//   Parametrised successor of the 2-VC/2-destination transaction path. Routes words from one input

---
 rtl/pcie_vc_router.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pcie_vc_router.sv
// Routes words from one input port through N_VC virtual-channel FIFOs into N_DEST destination FIFOs,
// with strict/round-robin VC arbitration, per-destination backpressure and a RESET/INIT/IDLE/ACTIVE/ERROR FSM.
module pcie_vc_router #(
   parameter int DATA_W     = 6,
   parameter int N_VC       = 2,
   parameter int N_DEST     = 2,
   parameter int VC_DEPTH   = 16,
   parameter int D_DEPTH    = 4,
   parameter int ARB_RR     = 1,
   parameter int VC_THR_DEF = 12,
   parameter int D_THR_DEF  = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         init,
   input  logic [$clog2(VC_DEPTH):0]    cfg_vc_thr,
   input  logic [$clog2(D_DEPTH):0]     cfg_d_thr,
   input  logic                         in_push,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         in_pause,
   input  logic [N_DEST-1:0]            d_pop,
   output logic [N_DEST*DATA_W-1:0]     d_data,
   output logic [N_DEST-1:0]            d_valid,
   output logic [N_DEST-1:0]            d_empty,
   output logic                         idle_out,
   output logic                         active_out,
   output logic                         error_out,
   output logic [$clog2(N_VC)-1:0]      error_id
);

   localparam int VCW  = $clog2(N_VC);
   localparam int DSTW = $clog2(N_DEST);
   localparam int VCA  = $clog2(VC_DEPTH);
   localparam int DA   = $clog2(D_DEPTH);
   localparam int VCC  = VCA + 1;
   localparam int DC   = DA + 1;

   typedef enum logic [2:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;

   state_t                 state_q, state_d;
   logic [VCC-1:0]         vc_thr_q;
   logic [DC-1:0]          d_thr_q;
   logic [VCW-1:0]         rr_q;
   logic [VCW-1:0]         error_id_q;
   logic [N_DEST*DATA_W-1:0] d_data_q;
   logic [N_DEST-1:0]      d_valid_q;

   logic [DATA_W-1:0]      vc_mem_q [N_VC][VC_DEPTH];
   logic [VCA-1:0]         vc_wp_q  [N_VC];
   logic [VCA-1:0]         vc_rp_q  [N_VC];
   logic [VCC-1:0]         vc_cnt_q [N_VC];
   logic [DATA_W-1:0]      d_mem_q  [N_DEST][D_DEPTH];
   logic [DA-1:0]          d_wp_q   [N_DEST];
   logic [DA-1:0]          d_rp_q   [N_DEST];
   logic [DC-1:0]          d_cnt_q  [N_DEST];

   logic [VCC-1:0]         vc_thr_eff;
   logic [DC-1:0]          d_thr_eff;
   logic [VCW-1:0]         in_vc;
   logic                   run_st, xfer_st, push_ok, in_full, push_acc, overflow;
   logic [N_VC-1:0]        vc_af, elig, vc_push, vc_pop, vc_ne;
   logic [N_DEST-1:0]      d_af, d_push, d_pop_acc, d_ne;
   logic [DATA_W-1:0]      head_word [N_VC];
   logic [DSTW-1:0]        head_dst  [N_VC];
   logic                   gnt_vld;
   logic [VCW-1:0]         gnt_idx, cand;
   logic [DSTW-1:0]        gnt_dst;
   logic [DATA_W-1:0]      gnt_word;

   // A zero threshold means the FIFO is only almost-full when completely full.
   assign vc_thr_eff = (vc_thr_q == '0) ? VCC'(VC_DEPTH) : vc_thr_q;
   assign d_thr_eff  = (d_thr_q == '0) ? DC'(D_DEPTH) : d_thr_q;

   assign run_st   = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
   assign xfer_st  = (state_q != ST_RESET) && (state_q != ST_INIT);
   assign in_vc    = in_data[DATA_W-1 -: VCW];
   assign push_ok  = in_push && run_st;
   assign in_full  = (vc_cnt_q[in_vc] == VCC'(VC_DEPTH));
   assign push_acc = push_ok && !in_full;
   assign overflow = push_ok && in_full;

   always_comb begin
      for (int v = 0; v < N_VC; v++) begin
         head_word[v] = vc_mem_q[v][vc_rp_q[v]];
         head_dst[v]  = head_word[v][DATA_W-1-VCW -: DSTW];
         vc_ne[v]     = (vc_cnt_q[v] != '0);
         vc_af[v]     = (vc_cnt_q[v] >= vc_thr_eff);
         vc_push[v]   = push_acc && (in_vc == VCW'(v));
      end
      // Also gate on full so a threshold programmed above the depth cannot overflow a destination.
      for (int k = 0; k < N_DEST; k++) begin
         d_ne[k]      = (d_cnt_q[k] != '0);
         d_af[k]      = (d_cnt_q[k] >= d_thr_eff) || (d_cnt_q[k] == DC'(D_DEPTH));
         d_pop_acc[k] = d_pop[k] && (state_q != ST_RESET) && d_ne[k];
      end
      for (int v = 0; v < N_VC; v++) begin
         elig[v] = vc_ne[v] && !d_af[head_dst[v]] && xfer_st;
      end
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (ARB_RR == 0) begin
         for (int v = N_VC-1; v >= 0; v--) begin
            if (elig[v]) begin
               gnt_vld = 1'b1;
               gnt_idx = VCW'(v);
            end
         end
      end else begin
         // Walk from farthest to nearest after the pointer so the nearest eligible VC wins.
         for (int i = N_VC; i >= 1; i--) begin
            cand = rr_q + VCW'(i);
            if (elig[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      gnt_dst  = head_dst[gnt_idx];
      gnt_word = head_word[gnt_idx];
      for (int v = 0; v < N_VC; v++) begin
         vc_pop[v] = gnt_vld && (gnt_idx == VCW'(v));
      end
      for (int k = 0; k < N_DEST; k++) begin
         d_push[k] = gnt_vld && (gnt_dst == DSTW'(k));
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   if (!init) state_d = ST_IDLE;
         ST_IDLE: begin
            if (overflow)                  state_d = ST_ERROR;
            else if (init)                 state_d = ST_INIT;
            else if ((|vc_ne) || (|d_ne))  state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (overflow)                  state_d = ST_ERROR;
            else if (init)                 state_d = ST_INIT;
            else if (!(|vc_ne) && !(|d_ne)) state_d = ST_IDLE;
         end
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RESET;
         vc_thr_q   <= VCC'(VC_THR_DEF);
         d_thr_q    <= DC'(D_THR_DEF);
         rr_q       <= VCW'(N_VC-1);
         error_id_q <= '0;
         d_data_q   <= '0;
         d_valid_q  <= '0;
         for (int v = 0; v < N_VC; v++) begin
            vc_wp_q[v]  <= '0;
            vc_rp_q[v]  <= '0;
            vc_cnt_q[v] <= '0;
         end
         for (int k = 0; k < N_DEST; k++) begin
            d_wp_q[k]  <= '0;
            d_rp_q[k]  <= '0;
            d_cnt_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (state_q == ST_INIT) begin
            vc_thr_q <= cfg_vc_thr;
            d_thr_q  <= cfg_d_thr;
         end
         if (overflow) error_id_q <= in_vc;
         if (gnt_vld)  rr_q <= gnt_idx;
         d_valid_q <= d_pop_acc;
         for (int v = 0; v < N_VC; v++) begin
            if (vc_push[v]) vc_wp_q[v] <= vc_wp_q[v] + 1'b1;
            if (vc_pop[v])  vc_rp_q[v] <= vc_rp_q[v] + 1'b1;
            vc_cnt_q[v] <= vc_cnt_q[v] + VCC'(vc_push[v]) - VCC'(vc_pop[v]);
         end
         for (int k = 0; k < N_DEST; k++) begin
            if (d_push[k]) d_wp_q[k] <= d_wp_q[k] + 1'b1;
            if (d_pop_acc[k]) begin
               d_rp_q[k] <= d_rp_q[k] + 1'b1;
               d_data_q[k*DATA_W +: DATA_W] <= d_mem_q[k][d_rp_q[k]];
            end
            d_cnt_q[k] <= d_cnt_q[k] + DC'(d_push[k]) - DC'(d_pop_acc[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) vc_mem_q[in_vc][vc_wp_q[in_vc]] <= in_data;
      if (gnt_vld)  d_mem_q[gnt_dst][d_wp_q[gnt_dst]] <= gnt_word;
   end

   assign in_pause   = (|vc_af) || (state_q == ST_RESET) || (state_q == ST_INIT) || (state_q == ST_ERROR);
   assign d_data     = d_data_q;
   assign d_valid    = d_valid_q;
   assign d_empty    = ~d_ne;
   assign idle_out   = (state_q == ST_IDLE);
   assign active_out = (state_q == ST_ACTIVE);
   assign error_out  = (state_q == ST_ERROR);
   assign error_id   = error_id_q;

endmodule
